// File: rtl/lbm_step_sequencer.sv
// lbm_step_sequencer: run-control for the LBM solver and its DMA snapshot path.
// The block runs a programmed number of solver steps and flips the ping-pong bank after each step.
// Every snap_interval steps it parks the solver and holds a frame-export request until the DMA
// reports that the frame is done.
// Optional feature: define LBM_SEQ_WDOG_EN to add a watchdog. The watchdog trips into a sticky
// ERR state if STEP or SNAP makes no progress for 2^TIMEOUT_W-1 cycles.
module lbm_step_sequencer #(
    parameter int STEP_W    = 32,
    parameter int SNAP_W    = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [STEP_W-1:0] step_target,
    input  logic [SNAP_W-1:0] snap_interval,
    input  logic              solver_step_done,
    input  logic              dma_frame_done,
    output logic              solver_en,
    output logic              bank_sel,
    output logic              dma_frame_req,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Reject parameter values that would give zero-width counters.
    if (STEP_W < 1 || SNAP_W < 1 || TIMEOUT_W < 2) begin : g_param_check
        $error("lbm_step_sequencer: STEP_W/SNAP_W must be >= 1 and TIMEOUT_W >= 2");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STEP = 3'd1,
        SNAP = 3'd2,
        DONE = 3'd3
`ifdef LBM_SEQ_WDOG_EN
        ,
        ERR  = 3'd4
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] target_q, target_d;
    logic [SNAP_W-1:0] interval_q, interval_d;
    logic [SNAP_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;
    logic              bank_sel_q, bank_sel_d;
    logic              solver_en_q, solver_en_d;
    logic              dma_frame_req_q, dma_frame_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [STEP_W-1:0] step_inc;
    logic [SNAP_W-1:0] snap_inc;
    logic              snap_due;

`ifdef LBM_SEQ_WDOG_EN
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 wdog_kick;
`endif

    // Step counter saturates instead of wrapping. Snap counter stays below the interval, so it never wraps.
    always_comb begin
        step_inc = (step_count_q == '1) ? step_count_q : step_count_q + STEP_W'(1);
        snap_inc = snap_cnt_q + SNAP_W'(1);
        snap_due = (interval_q != '0) && (snap_inc == interval_q);
    end

    // Next-state and next-output computation; outputs are decoded from the next state so they register.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d      = state_q;
        target_d     = target_q;
        interval_d   = interval_q;
        snap_cnt_d   = snap_cnt_q;
        step_count_d = step_count_q;
        bank_sel_d   = bank_sel_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d     = step_target;
                    interval_d   = snap_interval;
                    step_count_d = '0;
                    snap_cnt_d   = '0;
                    bank_sel_d   = 1'b0;
                    state_d      = (step_target == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                if (solver_step_done) begin
                    step_count_d = step_inc;
                    bank_sel_d   = ~bank_sel_q;
                    if (interval_q != '0) begin
                        snap_cnt_d = snap_due ? '0 : snap_inc;
                    end
                    // A snapshot due on the final step wins. SNAP then exits to DONE.
                    if (snap_due) begin
                        state_d = SNAP;
                    end else if (step_inc == target_q || stop) begin
                        state_d = DONE;
                    end
                end
            end
            SNAP: begin
                if (dma_frame_done) begin
                    state_d = (step_count_q == target_q || stop) ? DONE : STEP;
                end
            end
`ifdef LBM_SEQ_WDOG_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LBM_SEQ_WDOG_EN
        // Any handshake counts as progress. Entering a new state also restarts the count.
        wdog_kick = solver_step_done || dma_frame_done || (state_d != state_q);
        if (wdog_kick || !(state_q == STEP || state_q == SNAP)) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
        end
        if ((state_q == STEP || state_q == SNAP) && !wdog_kick && wdog_q == WDOG_LAST) begin
            state_d = ERR;
            wdog_d  = '0;
        end
`endif

        solver_en_d     = (state_d == STEP);
        dma_frame_req_d = (state_d == SNAP);
        busy_d          = (state_d == STEP) || (state_d == SNAP);
        done_d          = (state_d == DONE);
`ifdef LBM_SEQ_WDOG_EN
        error_d         = (state_d == ERR);
`else
        error_d         = 1'b0;
`endif
    end

    // State, run parameters, counters and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            target_q        <= '0;
            interval_q      <= '0;
            snap_cnt_q      <= '0;
            step_count_q    <= '0;
            bank_sel_q      <= 1'b0;
            solver_en_q     <= 1'b0;
            dma_frame_req_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q         <= state_d;
            target_q        <= target_d;
            interval_q      <= interval_d;
            snap_cnt_q      <= snap_cnt_d;
            step_count_q    <= step_count_d;
            bank_sel_q      <= bank_sel_d;
            solver_en_q     <= solver_en_d;
            dma_frame_req_q <= dma_frame_req_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

`ifdef LBM_SEQ_WDOG_EN
    // Watchdog cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign solver_en     = solver_en_q;
    assign bank_sel      = bank_sel_q;
    assign dma_frame_req = dma_frame_req_q;
    assign step_count    = step_count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// tb_lbm_step_sequencer: directed bench for lbm_step_sequencer.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
// A step_done pulse therefore takes effect on the next edge.
module tb_lbm_step_sequencer;

    localparam int STEP_W    = 32;
    localparam int SNAP_W    = 16;
    localparam int TIMEOUT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [STEP_W-1:0] step_target;
    logic [SNAP_W-1:0] snap_interval;
    logic              solver_step_done;
    logic              dma_frame_done;
    logic              solver_en;
    logic              bank_sel;
    logic              dma_frame_req;
    logic [STEP_W-1:0] step_count;
    logic              busy;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    lbm_step_sequencer #(
        .STEP_W   (STEP_W),
        .SNAP_W   (SNAP_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .step_target     (step_target),
        .snap_interval   (snap_interval),
        .solver_step_done(solver_step_done),
        .dma_frame_done  (dma_frame_done),
        .solver_en       (solver_en),
        .bank_sel        (bank_sel),
        .dma_frame_req   (dma_frame_req),
        .step_count      (step_count),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pulse();
        solver_step_done = 1'b1;
        tick();
        solver_step_done = 1'b0;
    endtask

    task automatic frame_pulse();
        dma_frame_done = 1'b1;
        tick();
        dma_frame_done = 1'b0;
    endtask

    task automatic start_run(input logic [STEP_W-1:0] tgt, input logic [SNAP_W-1:0] itv);
        step_target   = tgt;
        snap_interval = itv;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_solver_en"}, solver_en, 0);
        check({tag, "_bank_sel"}, bank_sel, 0);
        check({tag, "_req"}, dma_frame_req, 0);
        check({tag, "_step_count"}, step_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        step_target = '0;
        snap_interval = '0;
        solver_step_done = 1'b0;
        dma_frame_done = 1'b0;
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        // T1: five steps, no snapshots.
        start_run(5, 0);
        check("t1_start_solver_en", solver_en, 1);
        check("t1_start_busy", busy, 1);
        check("t1_start_count", step_count, 0);
        for (int s = 1; s <= 5; s++) begin
            repeat (9) begin
                tick();
                check("t1_no_req", dma_frame_req, 0);
            end
            step_pulse();
            check("t1_count", step_count, s);
            check("t1_bank", bank_sel, s % 2);
            check("t1_solver_en", solver_en, s < 5);
            check("t1_done", done, s == 5);
            check("t1_req", dma_frame_req, 0);
        end
        check("t1_busy_end", busy, 0);

        // T2: six steps, snapshot every two. Stray handshakes in the wrong state are ignored.
        start_run(6, 2);
        check("t2_start_count", step_count, 0);
        check("t2_start_bank", bank_sel, 0);
        check("t2_start_solver_en", solver_en, 1);
        frame_pulse();
        check("t2_stray_frame_done", solver_en, 1);
        check("t2_stray_frame_req", dma_frame_req, 0);
        for (int s = 1; s <= 6; s++) begin
            repeat (3) tick();
            step_pulse();
            check("t2_count", step_count, s);
            check("t2_bank", bank_sel, s % 2);
            if (s % 2 == 0) begin
                check("t2_snap_req", dma_frame_req, 1);
                check("t2_snap_solver_en", solver_en, 0);
                check("t2_snap_busy", busy, 1);
                check("t2_snap_done", done, 0);
                step_pulse();
                check("t2_snap_ignore_step", step_count, s);
                repeat (3) begin
                    tick();
                    check("t2_snap_hold_req", dma_frame_req, 1);
                    check("t2_snap_hold_en", solver_en, 0);
                end
                frame_pulse();
                check("t2_frame_req_drop", dma_frame_req, 0);
                check("t2_resume_solver_en", solver_en, s < 6);
                check("t2_done", done, s == 6);
            end else begin
                check("t2_step_req", dma_frame_req, 0);
                check("t2_step_solver_en", solver_en, 1);
            end
        end
        check("t2_final_count", step_count, 6);

        // T3: stop coincident with the fourth step_done; that step is still counted.
        start_run(100, 0);
        repeat (3) begin
            tick();
            step_pulse();
        end
        check("t3_count3", step_count, 3);
        tick();
        stop = 1'b1;
        solver_step_done = 1'b1;
        tick();
        solver_step_done = 1'b0;
        check("t3_count", step_count, 4);
        check("t3_done", done, 1);
        check("t3_solver_en", solver_en, 0);
        check("t3_bank", bank_sel, 0);
        tick();
        check("t3_stop_in_done", done, 1);
        stop = 1'b0;

        // T4: zero target finishes without enabling the solver.
        start_run(0, 0);
        check("t4_done", done, 1);
        check("t4_solver_en", solver_en, 0);
        check("t4_busy", busy, 0);
        repeat (3) begin
            tick();
            check("t4_solver_en_hold", solver_en, 0);
        end

        // T4b: a start pulse during STEP is ignored, including its new target.
        start_run(3, 0);
        step_pulse();
        check("t4b_count1", step_count, 1);
        start_run(1, 0);
        check("t4b_ignored_count", step_count, 1);
        check("t4b_ignored_bank", bank_sel, 1);
        check("t4b_still_busy", busy, 1);
        step_pulse();
        check("t4b_not_done", done, 0);
        step_pulse();
        check("t4b_done", done, 1);
        check("t4b_count3", step_count, 3);

        // T5: asynchronous reset mid-SNAP, then a clean run.
        start_run(10, 1);
        step_pulse();
        check("t5_in_snap", dma_frame_req, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async_rst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        start_run(2, 0);
        check("t5_restart_bank", bank_sel, 0);
        check("t5_restart_en", solver_en, 1);
        check("t5_restart_req", dma_frame_req, 0);
        step_pulse();
        check("t5_bank1", bank_sel, 1);
        step_pulse();
        check("t5_done", done, 1);
        check("t5_count", step_count, 2);
        check("t5_bank0", bank_sel, 0);
        check("t5_error", error, 0);

`ifdef LBM_SEQ_WDOG_EN
        // T6: the watchdog trips 15 cycles after STEP entry, and ERR is left only via reset.
        start_run(5, 0);
        check("t6_solver_en", solver_en, 1);
        repeat (14) begin
            tick();
            check("t6_no_error_yet", error, 0);
        end
        tick();
        check("t6_error", error, 1);
        check("t6_solver_en_off", solver_en, 0);
        check("t6_busy_off", busy, 0);
        start_run(5, 0);
        check("t6_start_ignored", error, 1);
        check("t6_start_ignored_en", solver_en, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_error_cleared", error, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
